sumador_multibyte_ctrl: RTL and testbench

//  Sequencer that performs a wide (8*NBYTES-bit) addition by time-multiplexing one

---
 rtl/sumador_multibyte_ctrl_if.sv | 34 +++
 rtl/sumador_multibyte_ctrl.sv | 113 +++++++++++
 tb/tb_sumador_multibyte_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/sumador_multibyte_ctrl_if.sv
// Bus bundle for the multibyte adder sequencer: operand/result side plus the
// byte-wide link to the shared external 8-bit adder.
interface sumador_multibyte_ctrl_if #(
  parameter int unsigned NBYTES = 4
);
  localparam int unsigned W = 8 * NBYTES;

  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;
  logic [7:0]   add_a;
  logic [7:0]   add_b;
  logic         add_cin;
  logic [7:0]   add_s;
  logic         add_cout;

  // Sequencer side
  modport slave (
    input  start, op_a, op_b, c_in, add_s, add_cout,
    output busy, done, sum, c_out, ovf, add_a, add_b, add_cin
  );

  // Requester plus shared adder side
  modport master (
    output start, op_a, op_b, c_in, add_s, add_cout,
    input  busy, done, sum, c_out, ovf, add_a, add_b, add_cin
  );
endinterface

// File: rtl/sumador_multibyte_ctrl.sv
// Wide adder sequencer: streams one byte per clock (LSB first) through a shared
// external 8-bit adder, chaining the carry through an internal register.
module sumador_multibyte_ctrl #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  sumador_multibyte_ctrl_if.slave     bus
);
  localparam int unsigned W  = 8 * NBYTES;
  localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_lat, b_lat;
  logic [W-1:0]  work_q, work_d;
  logic [W-1:0]  sum_q;
  logic          carry_q;
  logic          c_out_q;
  logic          ovf_q;
  logic [IW-1:0] idx_q;
  logic [IW+2:0] bofs;

  // Bit offset of the byte currently being processed
  assign bofs = {idx_q, 3'b000};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, adder drive and the working word with the current byte merged in
  always_comb begin
    state_d     = state_q;
    bus.add_a   = 8'h00;
    bus.add_b   = 8'h00;
    bus.add_cin = 1'b0;
    work_d      = work_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        bus.add_a          = a_lat[bofs +: 8];
        bus.add_b          = b_lat[bofs +: 8];
        bus.add_cin        = carry_q;
        work_d[bofs +: 8]  = bus.add_s;
        if (idx_q == LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Operand latches, byte index, carry chain and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_lat   <= '0;
      b_lat   <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            a_lat   <= bus.op_a;
            b_lat   <= bus.op_b;
            carry_q <= bus.c_in;
            idx_q   <= '0;
          end
        end
        S_RUN: begin
          work_q  <= work_d;
          carry_q <= bus.add_cout;
          if (idx_q == LAST) begin
            sum_q   <= work_d;
            c_out_q <= bus.add_cout;
            ovf_q   <= (a_lat[W-1] == b_lat[W-1]) && (work_d[W-1] != a_lat[W-1]);
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Status and result outputs, all decoded from registers
  assign bus.busy  = (state_q == S_RUN);
  assign bus.done  = (state_q == S_DONE);
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_sumador_multibyte_ctrl.sv
// Scoreboard bench for the multibyte adder sequencer with a behavioural 8-bit adder.
module tb_sumador_multibyte_ctrl;
  localparam int unsigned NB = 4;

  typedef struct packed {
    logic [31:0] sum;
    logic        c_out;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t exp_q[$];
  bit   mon_en;
  bit   want_cin1;
  int   cin1_cnt;
  exp_t e_mon;

  sumador_multibyte_ctrl_if #(.NBYTES(NB)) bus ();

  sumador_multibyte_ctrl #(.NBYTES(NB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Shared external ripple adder
  assign {bus.add_cout, bus.add_s} = 9'(bus.add_a) + 9'(bus.add_b) + 9'(bus.add_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse, polices the adder drive
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 expected=0");
        end else begin
          e_mon = exp_q.pop_front();
          chk("result_sum", bus.sum, e_mon.sum);
          chk("result_c_out", 32'(bus.c_out), 32'(e_mon.c_out));
          chk("result_ovf", 32'(bus.ovf), 32'(e_mon.ovf));
        end
      end
      if (!bus.busy) begin
        chk("idle_adder_drive", {15'd0, bus.add_cin, bus.add_b, bus.add_a}, 32'd0);
      end else if (want_cin1) begin
        cin1_cnt++;
        chk("wrap_add_cin", 32'(bus.add_cin), 32'd1);
      end
    end
  end

  // One complete operation: issue, push expectation, measure start-to-done latency
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic [31:0] es, input logic ec, input logic eo, input string name);
    exp_t e;
    int   lat;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.c_in  = cin;
    e.sum = es; e.c_out = ec; e.ovf = eo;
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    chk({name, "_latency"}, 32'(lat), 32'(NB));
  endtask

  initial begin
    logic [5:0] pat;
    int         tacc [3];
    int         nacc;
    int         cyc;
    logic       prev;
    exp_t       e;

    checks    = 0;
    errors    = 0;
    mon_en    = 1'b0;
    want_cin1 = 1'b0;
    cin1_cnt  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    bus.c_in  = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    chk("reset_sum", bus.sum, 32'd0);
    chk("reset_flags", {27'd0, bus.c_out, bus.ovf, bus.busy, bus.done, 1'b0}, 32'd0);
    chk("reset_adder_drive", {15'd0, bus.add_cin, bus.add_b, bus.add_a}, 32'd0);

    // Carry chain across the first byte boundary
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, "carry_chain");

    // Full wrap with carry in; carry must ride every byte
    want_cin1 = 1'b1;
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, "full_wrap");
    want_cin1 = 1'b0;
    chk("wrap_cin_cycles", 32'(cin1_cnt), 32'(NB));

    // Signed overflow
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "signed_ovf");

    // start pulsed in RUN and DONE, operands changed mid-RUN
    @(posedge clk); #1;
    pat[5]    = bus.busy;
    bus.start = 1'b1;
    bus.op_a  = 32'h0000_FFFF;
    bus.op_b  = 32'h0000_0001;
    bus.c_in  = 1'b0;
    e.sum = 32'h0001_0000; e.c_out = 1'b0; e.ovf = 1'b0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    pat[4]   = bus.busy;
    bus.op_a = 32'hDEAD_BEEF;
    bus.op_b = 32'h1234_5678;
    bus.c_in = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      @(posedge clk); #1;
      pat[i] = bus.busy;
    end
    @(posedge clk); #1;
    pat[0] = bus.busy;
    chk("ignore_done_pulse", 32'(bus.done), 32'd1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("ignore_no_queue_a", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    chk("ignore_no_queue_b", 32'(bus.busy), 32'd0);
    chk("busy_pattern", 32'(pat), 32'(6'b011110));

    // Reset during the second RUN cycle aborts without a result
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.op_a  = 32'h0F0F_0F0F;
    bus.op_b  = 32'h0101_0101;
    bus.c_in  = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_sum", bus.sum, 32'd0);
    chk("abort_state", {30'd0, bus.busy, bus.done}, 32'd0);
    repeat (8) @(posedge clk);
    #1;
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, "after_abort");

    // Back-to-back with start held high
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.op_a  = 32'h8000_0000;
    bus.op_b  = 32'h8000_0000;
    bus.c_in  = 1'b0;
    e.sum = 32'h0000_0000; e.c_out = 1'b1; e.ovf = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(e);
    nacc = 0;
    cyc  = 0;
    prev = bus.busy;
    tacc[0] = 0; tacc[1] = 0; tacc[2] = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.busy && !prev) begin
        tacc[nacc] = cyc;
        nacc++;
      end
      prev = bus.busy;
      if (nacc == 3) break;
    end
    bus.start = 1'b0;
    chk("b2b_accepts", 32'(nacc), 32'd3);
    chk("b2b_interval_1", 32'(tacc[1] - tacc[0]), 32'd6);
    chk("b2b_interval_2", 32'(tacc[2] - tacc[1]), 32'd6);
    repeat (8) @(posedge clk);
    #1;

    // Both operands negative with carry in
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, "neg_neg");

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
